// File: rtl/video_pixel_blend_pkg.sv
// Shared video definitions: ARGB4444 field layout, output width, fade range
// and the pixel pipeline depth.
package video_pixel_blend_pkg;

    localparam int CH_W     = 4;
    localparam int NUM_CH   = 3;
    localparam int A_LSB    = 12;
    localparam int R_LSB    = 8;
    localparam int G_LSB    = 4;
    localparam int B_LSB    = 0;
    localparam int OUT_W    = 12;
    localparam int FADE_MAX = 16;
    localparam int LATENCY  = 2;

    typedef struct packed {
        logic             vd;
        logic [OUT_W-1:0] rgb;
        logic [4:0]       fade;
    } s1_t;

    // Maps alpha 0..15 onto weight 0..16 so that A=15 is fully opaque.
    function automatic logic [4:0] alpha_weight(input logic [CH_W-1:0] a);
        return {1'b0, a} + {4'b0000, a[CH_W-1]};
    endfunction

    function automatic logic [4:0] clamp_fade(input logic [4:0] f);
        return (f > 5'(FADE_MAX)) ? 5'(FADE_MAX) : f;
    endfunction

endpackage

// File: rtl/video_pixel_mul4x5.sv
// Per-channel scale: p = (a * b) >> 4 with truncation.
module video_pixel_mul4x5 (
    input  logic [3:0] a,
    input  logic [4:0] b,
    output logic [3:0] p
);

    logic [8:0] prod;

    assign prod = {5'b00000, a} * {4'b0000, b};
    assign p    = 4'(prod >> 4);

endmodule

// File: rtl/video_pixel_blend.sv
// Two-stage ARGB4444 -> RGB444 pipeline: alpha blend against a background
// colour (S1), then global fade (S2), with frame-synchronous shadow settings.
module video_pixel_blend
    import video_pixel_blend_pkg::*;
#(
    parameter int pColorDepth = 16,
    parameter int pCntWidth   = 20
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [pColorDepth-1:0]     iPixel,
    input  logic                       iPixelVd,
    output logic                       oPixelRdy,
    output logic [pColorDepth*3/4-1:0] oPixel,
    output logic                       oPixelVd,
    input  logic                       iPixelRdy,
    input  logic [OUT_W-1:0]           iBgColor,
    input  logic [4:0]                 iFade,
    input  logic                       iBlendEn,
    input  logic                       iFrameStart,
    output logic [pCntWidth-1:0]       oPixelCnt
);

    logic                 en;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [OUT_W-1:0]     sh_bg_reg;
    logic [4:0]           sh_fade_reg;
    logic                 sh_blend_reg;
    logic [OUT_W-1:0]     eff_bg;
    logic [4:0]           eff_fade;
    logic                 eff_blend;
    logic [4:0]           weight;
    s1_t                  s1_reg;
    s1_t                  s1_next;
    logic                 s2_vd_reg;
    logic [OUT_W-1:0]     s2_rgb_reg;
    logic [OUT_W-1:0]     c1_next;
    logic [OUT_W-1:0]     c2_next;
    logic [pCntWidth-1:0] cnt_reg;

    assign en        = ~s2_vd_reg | iPixelRdy;
    assign oPixelRdy = en;
    assign in_xfer   = iPixelVd & en;
    assign out_xfer  = s2_vd_reg & iPixelRdy;

    // A pixel accepted on the frame-start cycle already sees the new settings.
    assign eff_bg    = iFrameStart ? iBgColor : sh_bg_reg;
    assign eff_fade  = iFrameStart ? clamp_fade(iFade) : sh_fade_reg;
    assign eff_blend = iFrameStart ? iBlendEn : sh_blend_reg;
    assign weight    = alpha_weight(iPixel[A_LSB +: CH_W]);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_W-1:0] fg;
            logic [CH_W-1:0] bg;
            logic            fg_ge;
            logic [CH_W-1:0] diff;
            logic [CH_W-1:0] base;
            logic [4:0]      wsel;
            logic [CH_W-1:0] term;

            assign fg    = iPixel[gi*CH_W +: CH_W];
            assign bg    = eff_bg[gi*CH_W +: CH_W];
            assign fg_ge = (fg >= bg);
            // fg*w + bg*(16-w) rewritten as min + |fg-bg|*weight', which gives
            // the identical truncated result with a single unsigned multiply.
            assign diff  = fg_ge ? (fg - bg) : (bg - fg);
            assign base  = fg_ge ? bg : fg;
            assign wsel  = fg_ge ? weight : (5'(FADE_MAX) - weight);

            video_pixel_mul4x5 u_blend (
                .a (diff),
                .b (wsel),
                .p (term)
            );

            assign c1_next[gi*CH_W +: CH_W] = eff_blend ? (base + term) : fg;

            video_pixel_mul4x5 u_fade (
                .a (s1_reg.rgb[gi*CH_W +: CH_W]),
                .b (s1_reg.fade),
                .p (c2_next[gi*CH_W +: CH_W])
            );
        end
    endgenerate

    // The fade value travels with the pixel so later shadow loads cannot affect it.
    always_comb begin
        s1_next      = s1_reg;
        s1_next.vd   = in_xfer;
        s1_next.rgb  = c1_next;
        s1_next.fade = eff_fade;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            sh_bg_reg    <= '0;
            sh_fade_reg  <= 5'(FADE_MAX);
            sh_blend_reg <= 1'b0;
        end else if (iFrameStart) begin
            sh_bg_reg    <= iBgColor;
            sh_fade_reg  <= clamp_fade(iFade);
            sh_blend_reg <= iBlendEn;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            s1_reg     <= '0;
            s2_vd_reg  <= 1'b0;
            s2_rgb_reg <= '0;
        end else if (en) begin
            s1_reg     <= s1_next;
            s2_vd_reg  <= s1_reg.vd;
            s2_rgb_reg <= c2_next;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnt_reg <= '0;
        end else if (iFrameStart) begin
            cnt_reg <= out_xfer ? {{(pCntWidth-1){1'b0}}, 1'b1} : '0;
        end else if (out_xfer) begin
            cnt_reg <= cnt_reg + {{(pCntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign oPixel    = s2_rgb_reg;
    assign oPixelVd  = s2_vd_reg;
    assign oPixelCnt = cnt_reg;

endmodule
